// File: rtl/seg7_mux.sv
// seg7_mux: multiplexed seven-segment driver with PWM brightness, leading-zero blanking and frame pulse
module seg7_mux #(
  parameter int NUM_DIGITS = 8,
  parameter int REFRESH_DIV = 65536,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_in_i,
  input  logic                    blank_lz_i,
  input  logic [3:0]              brightness_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    dp_o,
  output logic                    frame_done_o
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic DP_OFF = SEG_ACTIVE_LOW;

  logic [4*NUM_DIGITS-1:0] shd_data_q, shd_data_d;
  logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [DW-1:0]           div_cnt_q, div_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    fd_pend_q, fd_pend_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q;
  logic [NUM_DIGITS-1:0]   keep;
  logic [3:0]              nib;
  logic                    slot_end, frame_end, on, blanked, dp_sel, keep_sel;

  // lit-segment pattern, bit0=a .. bit6=g, active high
  function automatic logic [6:0] font(input logic [3:0] h);
    case (h)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h58;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      default: font = 7'h71;
    endcase
  endfunction

  // keep[i] is set when any nibble from i up to the top digit is nonzero
  always_comb begin
    keep = '0;
    keep[NUM_DIGITS-1] = |shd_data_q[4*NUM_DIGITS-1 -: 4];
    for (int i = NUM_DIGITS - 2; i >= 0; i--) keep[i] = keep[i+1] | (|shd_data_q[4*i +: 4]);
  end

  // shadow capture, slot/digit counters and the frame pulse one cycle behind the wrap
  always_comb begin
    shd_data_d = load_i ? data_i : shd_data_q;
    shd_dp_d   = load_i ? dp_in_i : shd_dp_q;
    slot_end   = div_cnt_q == DW'(REFRESH_DIV - 1);
    frame_end  = slot_end && idx_q == IW'(NUM_DIGITS - 1);
    div_cnt_d  = slot_end ? '0 : div_cnt_q + DW'(1);
    idx_d      = frame_end ? '0 : slot_end ? idx_q + IW'(1) : idx_q;
    fd_pend_d  = frame_end;
  end

  // next display outputs from the current digit, PWM phase and blanking state
  always_comb begin
    nib      = 4'(shd_data_q >> {idx_q, 2'b00});
    dp_sel   = 1'(shd_dp_q >> idx_q);
    keep_sel = 1'(keep >> idx_q);
    on       = div_cnt_q[3:0] < brightness_i;
    blanked  = blank_lz_i && idx_q != '0 && !keep_sel;
    seg_d    = (on && !blanked) ? font(nib) ^ SEG_OFF : SEG_OFF;
    an_d     = on ? (NUM_DIGITS'(1) << idx_q) ^ AN_OFF : AN_OFF;
    dp_d     = (on && dp_sel) ^ DP_OFF;
  end

  // state and registered outputs, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shd_data_q   <= '0;
      shd_dp_q     <= '0;
      div_cnt_q    <= '0;
      idx_q        <= '0;
      fd_pend_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      dp_q         <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      shd_data_q   <= shd_data_d;
      shd_dp_q     <= shd_dp_d;
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      fd_pend_q    <= fd_pend_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      frame_done_q <= fd_pend_q;
    end
  end

  assign seg_o        = seg_q;
  assign an_o         = an_q;
  assign dp_o         = dp_q;
  assign frame_done_o = frame_done_q;
endmodule

// File: doc/seg7_mux.md
# seg7_mux

Parametrised multiplexed seven-segment display driver. It replaces the fixed 8-digit hex display driver and sits between the CPU debug/status register and the board's common-anode display. It adds a configurable digit count, refresh rate and output polarity. New behaviour: load-strobe data capture, per-digit decimal points, leading-zero blanking, 16-level PWM brightness, and a frame-done pulse.

## Interface
- NUM_DIGITS, 8, number of digits; legal range 1..16.
- REFRESH_DIV, 65536, clock cycles per digit slot; must be a multiple of 16 and at least 16.
- SEG_ACTIVE_LOW, 1, 1 means seg and dp drive 0 to light.
- AN_ACTIVE_LOW, 1, 1 means an drives 0 to enable a digit.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- load  in  1  one-cycle strobe that captures data and dp_in.
- data  in  4*NUM_DIGITS  hex nibbles; digit i is data[4i+3:4i], and digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- blank_lz  in  1  enables leading-zero suppression.
- brightness  in  4  on-time in sixteenths (0 = dark, 15 = 15/16).
- seg  out  7  segments; bit0=a through bit6=g.
- an  out  NUM_DIGITS  one-hot digit enable.
- dp  out  1  decimal point.
- frame_done  out  1  one-cycle pulse when a full scan completes.

## Operation
- Shadow registers shd_data and shd_dp:
  - On a clk edge with load=1, they take data and dp_in.
  - They otherwise hold.
  - Reset value is 0.
  - load is ignored while reset is high.
- Slot counter div_cnt runs 0..REFRESH_DIV-1 and wraps to 0.
- Digit index idx advances at each div_cnt wrap and runs 0..NUM_DIGITS-1, wrapping to 0.
  - The wrap of idx from NUM_DIGITS-1 to 0 raises frame_done for exactly one cycle.
  - With NUM_DIGITS=1, frame_done pulses every slot.
- PWM: the digit is enabled while div_cnt[3:0] < brightness. Outside the on-time, an, seg and dp are all at their inactive levels.
- Leading-zero blanking: with blank_lz=1, digit i (i>0) is blanked if shd_data nibbles i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives seg inactive, but its anode still follows PWM and its dp still follows shd_dp[i].
- Font (lit segments):
  - 0: abcdef; 1: bc; 2: abdeg; 3: abcdg; 4: bcfg; 5: acdfg; 6: acdefg; 7: abc.
  - 8: abcdefg; 9: abcdfg; A: abcefg; b: cdefg; c: deg; d: bcdeg; E: adefg; F: aefg.
- Polarity: the parameters invert seg/dp and an respectively. Inactive level is 1 when the parameter is 1, and 0 when it is 0.

## Timing
- All outputs are registered. They reflect shd_*, idx, div_cnt and brightness as they stood one cycle earlier.
- Reset (asynchronous, immediate) sets:
  - div_cnt=0, idx=0, frame_done=0.
  - an, seg, dp at their inactive levels.
- First lit output appears on the first clk edge after reset deasserts, provided brightness>0.
- Load latency: load sampled at edge N updates shd_* at edge N. The value appears on seg at edge N+1, when that digit's slot is active.
- Load during an active slot changes that digit mid-slot. No tearing protection is required.
- brightness is sampled every cycle. A change takes effect on the next cycle's output.
- frame_done asserts on the edge after the cycle where idx=NUM_DIGITS-1 and div_cnt=REFRESH_DIV-1, i.e. it is aligned with digit 0's first output.
- Reset asserted mid-scan: all state returns to reset values at once. Shadow contents are lost (reset to 0).

## Test plan
Bench configuration: NUM_DIGITS=4, REFRESH_DIV=16, default polarities, brightness=15 unless stated.
- **Reset state.** Hold reset -> an=4'b1111, seg=7'h7F, dp=1, frame_done=0. Release reset -> an=4'b1110 and seg shows "0" (7'b1000000) on the next edge.
- **Load and scan.** load with data=16'h12AB and dp_in=4'b0100, then scan one frame. Required sequence:
  - Digits B, A, 2, 1 on an=1110, 1101, 1011, 0111, each for 15 of 16 cycles.
  - dp=0 only during digit 2.
  - frame_done is a single pulse every 64 cycles.
- **Leading-zero blanking.** data=16'h0050, blank_lz=1:
  - Digits 3 and 2 drive seg=7'h7F while their anode still pulses.
  - Digit 1 shows "5"; digit 0 shows "0".
  - With blank_lz=0, all four digits show.
- **Brightness.** brightness=0 -> an stays 4'b1111 for a full frame. brightness=4 -> each anode is active for exactly 4 of its 16 cycles, at div_cnt 0..3.
- **Reset mid-operation.** Assert reset at idx=2 with loaded data=16'hFFFF -> outputs go inactive immediately. After release, digit 0 shows "0" (shadow cleared).
- **Polarity.** SEG_ACTIVE_LOW=0 and AN_ACTIVE_LOW=0 with data=16'h8888 -> seg=7'h7F and an one-hot high during on-time; all zeros otherwise.
